// File: rtl/perspective_divide_viewport.sv
// perspective_divide_viewport: clip-space vertex -> screen pixel x/y plus [0,1] depth.
// A single iterative reciprocal of w feeds three scaling multiplies, then the viewport transform.
module perspective_divide_viewport #(
  parameter int DATAWIDTH     = 24,
  parameter int FRACBITS      = 13,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*DATAWIDTH-1:0]      i_vertex,
  input  logic                        i_vertex_valid,
  input  logic                        i_vertex_last,
  output logic                        o_ready,
  output logic signed [DATAWIDTH-1:0] o_pixel_x,
  output logic signed [DATAWIDTH-1:0] o_pixel_y,
  output logic signed [DATAWIDTH-1:0] o_depth,
  output logic                        o_clipped,
  output logic                        o_vertex_last,
  output logic                        o_valid,
  input  logic                        i_ready
);

  localparam int DIV_STEPS = 2*FRACBITS + 1;
  localparam int STEPW     = $clog2(DIV_STEPS);
  localparam int PW        = 2*DATAWIDTH;

  localparam logic signed [PW-1:0] ONE_W  = {{(PW-FRACBITS-1){1'b0}}, 1'b1, {FRACBITS{1'b0}}};
  localparam logic signed [PW-1:0] HALF_W = PW'(SCREEN_WIDTH/2);
  localparam logic signed [PW-1:0] HALF_H = PW'(SCREEN_HEIGHT/2);
  localparam logic signed [PW-1:0] SAT_HI = {{(PW-DATAWIDTH+1){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(PW-DATAWIDTH+1){1'b1}}, {(DATAWIDTH-1){1'b0}}};
  localparam logic signed [DATAWIDTH-1:0] RECIP_MAX = {1'b0, {(DATAWIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DIVIDE   = 3'd1,
    SCALE    = 3'd2,
    VIEWPORT = 3'd3,
    OUTPUT   = 3'd4
  } state_t;

  function automatic logic signed [DATAWIDTH-1:0] sat_dw(input logic signed [PW-1:0] v);
    logic signed [DATAWIDTH-1:0] r;
    if (v > SAT_HI) r = SAT_HI[DATAWIDTH-1:0];
    else if (v < SAT_LO) r = SAT_LO[DATAWIDTH-1:0];
    else r = v[DATAWIDTH-1:0];
    return r;
  endfunction

  state_t                      state_r;
  logic signed [DATAWIDTH-1:0] x_r, y_r, z_r;
  logic [DATAWIDTH-1:0]        w_r;
  logic                        last_r;
  logic [DIV_STEPS-1:0]        num_r, quo_r;
  logic [DATAWIDTH-1:0]        rem_r;
  logic [STEPW-1:0]            step_r;
  logic signed [DATAWIDTH-1:0] ndc_x_r, ndc_y_r, ndc_z_r;

  logic signed [DATAWIDTH-1:0] w_in_s;
  logic                        clip_s;
  logic [DATAWIDTH-1:0]        trial_s, rem_next_s;
  logic                        q_bit_s;
  logic signed [DATAWIDTH-1:0] recip_s;
  logic signed [PW-1:0]        prod_x_s, prod_y_s, prod_z_s;
  logic signed [PW-1:0]        vp_x_s, vp_y_s, vp_z_s;

  // Clip decision on the incoming w (w <= 0 skips the divide).
  always_comb begin
    w_in_s = i_vertex[DATAWIDTH-1:0];
    clip_s = w_in_s[DATAWIDTH-1] | (w_in_s == {DATAWIDTH{1'b0}});
  end

  // Restoring divider step; the bit shifted out of rem_r guarantees trial >= w.
  always_comb begin
    trial_s = {rem_r[DATAWIDTH-2:0], num_r[DIV_STEPS-1]};
    if (rem_r[DATAWIDTH-1] || (trial_s >= w_r)) begin
      q_bit_s    = 1'b1;
      rem_next_s = trial_s - w_r;
    end else begin
      q_bit_s    = 1'b0;
      rem_next_s = trial_s;
    end
  end

  // Saturated reciprocal and the three full-width scaling products.
  always_comb begin
    if (|quo_r[DIV_STEPS-1:DATAWIDTH-1]) recip_s = RECIP_MAX;
    else recip_s = quo_r[DATAWIDTH-1:0];
    prod_x_s = x_r * recip_s;
    prod_y_s = y_r * recip_s;
    prod_z_s = z_r * recip_s;
  end

  // Viewport transform in widened arithmetic; y flips so screen y grows downward.
  always_comb begin
    vp_x_s = ((PW'(ndc_x_r) + ONE_W) * HALF_W) >>> FRACBITS;
    vp_y_s = ((ONE_W - PW'(ndc_y_r)) * HALF_H) >>> FRACBITS;
    vp_z_s = (PW'(ndc_z_r) + ONE_W) >>> 1;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      x_r           <= {DATAWIDTH{1'b0}};
      y_r           <= {DATAWIDTH{1'b0}};
      z_r           <= {DATAWIDTH{1'b0}};
      w_r           <= {DATAWIDTH{1'b0}};
      last_r        <= 1'b0;
      num_r         <= {DIV_STEPS{1'b0}};
      quo_r         <= {DIV_STEPS{1'b0}};
      rem_r         <= {DATAWIDTH{1'b0}};
      step_r        <= {STEPW{1'b0}};
      ndc_x_r       <= {DATAWIDTH{1'b0}};
      ndc_y_r       <= {DATAWIDTH{1'b0}};
      ndc_z_r       <= {DATAWIDTH{1'b0}};
      o_ready       <= 1'b0;
      o_pixel_x     <= {DATAWIDTH{1'b0}};
      o_pixel_y     <= {DATAWIDTH{1'b0}};
      o_depth       <= {DATAWIDTH{1'b0}};
      o_clipped     <= 1'b0;
      o_vertex_last <= 1'b0;
      o_valid       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_vertex_valid && o_ready) begin
            x_r     <= i_vertex[4*DATAWIDTH-1:3*DATAWIDTH];
            y_r     <= i_vertex[3*DATAWIDTH-1:2*DATAWIDTH];
            z_r     <= i_vertex[2*DATAWIDTH-1:DATAWIDTH];
            w_r     <= i_vertex[DATAWIDTH-1:0];
            last_r  <= i_vertex_last;
            o_ready <= 1'b0;
            if (clip_s) begin
              state_r       <= OUTPUT;
              o_pixel_x     <= {DATAWIDTH{1'b0}};
              o_pixel_y     <= {DATAWIDTH{1'b0}};
              o_depth       <= {DATAWIDTH{1'b0}};
              o_clipped     <= 1'b1;
              o_vertex_last <= i_vertex_last;
              o_valid       <= 1'b1;
            end else begin
              state_r <= DIVIDE;
              num_r   <= {1'b1, {(DIV_STEPS-1){1'b0}}};
              quo_r   <= {DIV_STEPS{1'b0}};
              rem_r   <= {DATAWIDTH{1'b0}};
              step_r  <= {STEPW{1'b0}};
            end
          end else begin
            o_ready <= 1'b1;
          end
        end
        DIVIDE: begin
          num_r  <= {num_r[DIV_STEPS-2:0], 1'b0};
          rem_r  <= rem_next_s;
          quo_r  <= {quo_r[DIV_STEPS-2:0], q_bit_s};
          step_r <= step_r + STEPW'(1);
          if (step_r == STEPW'(DIV_STEPS-1)) state_r <= SCALE;
          else state_r <= DIVIDE;
        end
        SCALE: begin
          ndc_x_r <= sat_dw(prod_x_s >>> FRACBITS);
          ndc_y_r <= sat_dw(prod_y_s >>> FRACBITS);
          ndc_z_r <= sat_dw(prod_z_s >>> FRACBITS);
          state_r <= VIEWPORT;
        end
        VIEWPORT: begin
          o_pixel_x     <= sat_dw(vp_x_s);
          o_pixel_y     <= sat_dw(vp_y_s);
          o_depth       <= sat_dw(vp_z_s);
          o_clipped     <= 1'b0;
          o_vertex_last <= last_r;
          o_valid       <= 1'b1;
          state_r       <= OUTPUT;
        end
        OUTPUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state_r <= IDLE;
          end else begin
            state_r <= OUTPUT;
          end
        end
        default: begin
          state_r <= IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/perspective_divide_viewport.md
Name: perspective_divide_viewport

Overview:
- Stage directly downstream of the vertex shader. Consumes clip-space vertices (x, y, z, w) in signed Q(FRACBITS) fixed point.
- Performs the perspective divide using one iterative reciprocal of w followed by three multiplies.
- Applies the viewport transform and emits screen-pixel x/y and a [0,1] depth to the rasterizer setup stage.
- Vertices with w <= 0 are flagged as clipped and skip the divide.

Parameters:
- DATAWIDTH, 24, width of all signed fixed-point data.
- FRACBITS, 13, fractional bits; ONE = 1 << FRACBITS.
- SCREEN_WIDTH, 640, viewport width in pixels (even).
- SCREEN_HEIGHT, 480, viewport height in pixels (even).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- i_vertex  in  4 x DATAWIDTH signed  clip-space {x, y, z, w}.
- i_vertex_valid  in  1  input vertex valid.
- i_vertex_last  in  1  marks the last vertex of a model.
- o_ready  out  1  block can accept a vertex this cycle.
- o_pixel_x  out  DATAWIDTH signed  screen x, integer pixels, unclamped.
- o_pixel_y  out  DATAWIDTH signed  screen y, integer pixels, unclamped, y down.
- o_depth  out  DATAWIDTH signed  depth, Q(FRACBITS), 0..ONE for in-frustum z.
- o_clipped  out  1  vertex had w <= 0; coordinate outputs are 0.
- o_vertex_last  out  1  registered copy of i_vertex_last.
- o_valid  out  1  outputs valid.
- i_ready  in  1  downstream accepts output.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; o_ready=0 during reset, 1 on the first clock after release.
  - All data outputs 0; o_valid, o_clipped, o_vertex_last = 0.
  - Divider registers are cleared. Reset mid-operation discards the vertex in flight; no output is produced.
- States: IDLE, DIVIDE, SCALE, VIEWPORT, OUTPUT.
- IDLE:
  - o_ready=1. Accept when i_vertex_valid && o_ready: register x, y, z, w and last; o_ready drops to 0 the next cycle.
  - If accepted w <= 0: go to OUTPUT with o_clipped=1 and all coordinate outputs 0.
  - Otherwise go to DIVIDE.
- DIVIDE:
  - Unsigned restoring division, N = 1 << (2*FRACBITS) by D = w, one quotient bit per cycle, DIV_STEPS = 2*FRACBITS+1 cycles (27 at defaults).
  - recip = floor(N/D), saturated to 2^(DATAWIDTH-1)-1.
  - Then go to SCALE.
- SCALE (1 cycle):
  - ndc_c = (c * recip) >>> FRACBITS for c in {x, y, z}.
  - Full 2*DATAWIDTH product, arithmetic shift (floor), saturate to the signed DATAWIDTH range.
- VIEWPORT (1 cycle):
  - px = ((ndc_x + ONE) * (SCREEN_WIDTH/2)) >>> FRACBITS.
  - py = ((ONE - ndc_y) * (SCREEN_HEIGHT/2)) >>> FRACBITS.
  - depth = (ndc_z + ONE) >>> 1.
  - Intermediates are widened to avoid overflow; results saturate to the signed DATAWIDTH range.
  - Then go to OUTPUT.
- OUTPUT:
  - o_valid=1; all outputs held stable while i_ready=0.
  - On i_ready=1: o_valid goes to 0 the next cycle, return to IDLE, o_ready=1 on that cycle.
- Latency, non-clipped: accept edge to o_valid=1 is DIV_STEPS+3 cycles (30 at defaults).
- Latency, clipped: accept edge to o_valid=1 is 1 cycle.
- Throughput: one vertex in flight at a time.
- No clamping to the screen: off-screen and edge values pass through (x=w gives px=SCREEN_WIDTH).
- i_vertex_valid while o_ready=0 is ignored; upstream must hold data until accepted.
- o_vertex_last is valid together with o_valid, including for clipped vertices.

Test Plan:
- Reset release: o_ready=1 in the first clock after release; all outputs 0.
- {0, 0, 0, 8192}, i_ready=1 -> after 30 cycles: px=320, py=240, depth=4096, o_clipped=0; o_ready=1 the cycle after the handshake.
- {4096, -4096, 8192, 16384} with last=1 -> recip=4096, px=400, py=300, depth=6144, o_vertex_last=1.
- w=0, then w=-8192 -> o_valid 1 cycle after accept, o_clipped=1, coordinate outputs 0, no DIVIDE cycles.
- {8192, -8192, -8192, 8192} with i_ready held 0 for 10 cycles -> px=640, py=480, depth=0; outputs held stable throughout; exactly one transfer on i_ready=1.
- Assert rst midway through DIVIDE -> outputs 0 immediately; no o_valid afterwards; the next vertex processes correctly.
